// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative 32-bit radix-2 restoring divider between
// two requesters (bit0 = integer execute, bit1 = FPU).
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o   per-requester request handshake
//   r0_*/r1_*                 operands and op (bit0 = unsigned, bit1 = remainder)
//   cancel_i                  per-requester abort of the in-flight op
//   rsp_valid_o/rsp_ready_i   one-hot (owner) response handshake
//   rsp_data_o                shared result register
//   busy_o                    high whenever the FSM is not IDLE
//
// Timing: accept edge A loads operands, RUN steps on edges A+1..A+32, FIX
// registers the result on A+33, and the response is held in RESP from then
// on, so it is first sampled valid on edge A+34.
module div_arbiter (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [1:0]  req_valid_i,
   output logic [1:0]  req_ready_o,
   input  logic [31:0] r0_dividend_i,
   input  logic [31:0] r0_divisor_i,
   input  logic [1:0]  r0_op_i,
   input  logic [31:0] r1_dividend_i,
   input  logic [31:0] r1_divisor_i,
   input  logic [1:0]  r1_op_i,
   input  logic [1:0]  cancel_i,
   output logic [1:0]  rsp_valid_o,
   input  logic [1:0]  rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, RESP} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q,  last_d;     // requester served last; 1 after reset so r0 wins a tie
   logic [1:0]  op_q,    op_d;
   logic        neg_q,   neg_d;
   logic [4:0]  cnt_q,   cnt_d;
   logic [31:0] rem_q,   rem_d;
   logic [31:0] quo_q,   quo_d;      // dividend shifts out MSB-first, quotient shifts in
   logic [31:0] dvs_q,   dvs_d;
   logic [31:0] data_q,  data_d;

   logic        gnt_any, gnt_id, accept, own_cancel, consume;
   logic [31:0] sel_a, sel_b, mag_a, mag_b, res;
   logic [1:0]  sel_op;
   logic        sel_signed;
   logic [32:0] shifted, diff;

   // ---------------- grant / handshake decode ----------------
   always_comb begin
      gnt_any = |req_valid_i;
      case (req_valid_i)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         default: gnt_id = ~last_q;   // tie: whoever was not served last
      endcase
      accept     = (state_q == IDLE) && gnt_any;
      own_cancel = cancel_i[owner_q];
      consume    = (state_q == RESP) && rsp_ready_i[owner_q];
   end

   // Operand selection and magnitude for the requester being granted
   always_comb begin
      sel_a      = gnt_id ? r1_dividend_i : r0_dividend_i;
      sel_b      = gnt_id ? r1_divisor_i  : r0_divisor_i;
      sel_op     = gnt_id ? r1_op_i       : r0_op_i;
      sel_signed = ~sel_op[0];
      mag_a      = (sel_signed && sel_a[31]) ? -sel_a : sel_a;
      mag_b      = (sel_signed && sel_b[31]) ? -sel_b : sel_b;
   end

   // One restoring step: a non-negative trial difference sets the quotient bit.
   // shifted < 2*divisor, so the 33-bit difference sign is exact.
   always_comb begin
      shifted = {rem_q, quo_q[31]};
      diff    = shifted - {1'b0, dvs_q};
      res     = op_q[1] ? rem_q : quo_q;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = RUN;
         RUN: begin
            if (own_cancel)       state_d = IDLE;
            else if (cnt_q == '0) state_d = FIX;
         end
         FIX:  state_d = own_cancel ? IDLE : RESP;
         RESP: if (consume || own_cancel) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      req_ready_o = 2'b00;
      rsp_valid_o = 2'b00;
      if (!reset_i && state_q == IDLE && gnt_any) req_ready_o = {gnt_id, ~gnt_id};
      if (!reset_i && state_q == RESP)            rsp_valid_o = {owner_q, ~owner_q};
      busy_o     = (state_q != IDLE);
      rsp_data_o = data_q;
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      owner_d = owner_q;
      last_d  = last_q;
      op_d    = op_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      data_d  = data_q;
      case (state_q)
         IDLE: if (accept) begin
            owner_d = gnt_id;
            op_d    = sel_op;
            // divide-by-zero quotient must stay all-ones, so no sign there
            neg_d   = sel_op[1] ? (sel_signed & sel_a[31])
                                : (sel_signed & (sel_a[31] ^ sel_b[31]) & (|sel_b));
            cnt_d   = 5'd31;
            rem_d   = '0;
            quo_d   = mag_a;
            dvs_d   = mag_b;
         end
         RUN: begin
            cnt_d = cnt_q - 5'd1;
            rem_d = diff[32] ? shifted[31:0] : diff[31:0];
            quo_d = {quo_q[30:0], ~diff[32]};
         end
         FIX:  if (!own_cancel) data_d = neg_q ? -res : res;
         RESP: if (consume) last_d = owner_q;   // consume wins over a same-edge cancel
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         op_q    <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         data_q  <= '0;
      end else begin
         owner_q <= owner_d;
         last_q  <= last_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [1:0]  req_valid_i = '0;
   logic [1:0]  req_ready_o;
   logic [31:0] r0_dividend_i = '0, r0_divisor_i = '0;
   logic [1:0]  r0_op_i = '0;
   logic [31:0] r1_dividend_i = '0, r1_divisor_i = '0;
   logic [1:0]  r1_op_i = '0;
   logic [1:0]  cancel_i = '0;
   logic [1:0]  rsp_valid_o;
   logic [1:0]  rsp_ready_i = '0;
   logic [31:0] rsp_data_o;
   logic        busy_o;

   div_arbiter dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .r0_dividend_i(r0_dividend_i), .r0_divisor_i(r0_divisor_i), .r0_op_i(r0_op_i),
      .r1_dividend_i(r1_dividend_i), .r1_divisor_i(r1_divisor_i), .r1_op_i(r1_op_i),
      .cancel_i(cancel_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          acc;     // cycle count of the accepting edge
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   last_grant = -1;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer division with the RISC-V corner cases.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
      longint q, r;
      if (b == 32'd0) begin
         q = 64'hFFFF_FFFF;
         r = {32'b0, a};
      end else if (op[0]) begin
         q = {32'b0, a} / {32'b0, b};
         r = {32'b0, a} % {32'b0, b};
      end else begin
         q = longint'($signed(a)) / longint'($signed(b));
         r = longint'($signed(a)) % longint'($signed(b));
      end
      return op[1] ? r[31:0] : q[31:0];
   endfunction

   // ---------------- monitor ----------------
   logic        in_rsp = 1'b0;
   logic [1:0]  hold_v = '0;
   logic [31:0] hold_d = '0;

   always @(negedge clk_i) begin
      exp_t e;
      if (reset_i) begin
         in_rsp <= 1'b0;
      end else begin
         if (req_ready_o == 2'b11) chk("ready_onehot", {30'b0, req_ready_o}, 32'd0);
         if (rsp_valid_o != 2'b00) begin
            if (!in_rsp) begin
               in_rsp <= 1'b1;
               hold_v <= rsp_valid_o;
               hold_d <= rsp_data_o;
               if (sb.size() == 0) begin
                  chk("unexpected_rsp", {30'b0, rsp_valid_o}, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_owner", {30'b0, rsp_valid_o}, (e.id == 1) ? 32'd2 : 32'd1);
                  chk("rsp_data", rsp_data_o, e.data);
                  // high after edge acc+33, i.e. first sampled on edge acc+34
                  chk("rsp_latency", cyc - e.acc, 32'd33);
               end
            end else begin
               chk("hold_valid", {30'b0, rsp_valid_o}, {30'b0, hold_v});
               chk("hold_data", rsp_data_o, hold_d);
            end
         end else begin
            in_rsp <= 1'b0;
         end
      end
   end

   // ---------------- driver ----------------
   // One cycle: log accepts seen before the edge, then drop accepted valids.
   task automatic step();
      logic [1:0] acc;
      exp_t e;
      @(negedge clk_i);
      acc = reset_i ? 2'b00 : (req_valid_i & req_ready_o);
      for (int i = 0; i < 2; i++) begin
         if (acc[i]) begin
            e.id   = i;
            e.acc  = cyc + 1;
            e.data = (i == 0) ? ref_div(r0_dividend_i, r0_divisor_i, r0_op_i)
                              : ref_div(r1_dividend_i, r1_divisor_i, r1_op_i);
            sb.push_back(e);
            last_grant = i;
         end
      end
      @(posedge clk_i);
      #1;
      req_valid_i = req_valid_i & ~acc;
   endtask

   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op);
      if (id == 0) begin
         r0_dividend_i = a; r0_divisor_i = b; r0_op_i = op; req_valid_i[0] = 1'b1;
      end else begin
         r1_dividend_i = a; r1_divisor_i = b; r1_op_i = op; req_valid_i[1] = 1'b1;
      end
   endtask

   // Wait for any accept, then check who got it.
   task automatic wait_acc(input int exp_id);
      logic [1:0] v0;
      int k;
      v0 = req_valid_i;
      k = 0;
      while (req_valid_i == v0 && k < 100) begin
         step();
         k++;
      end
      if (req_valid_i == v0) begin
         chk("accept_timeout", {30'b0, req_valid_i}, {30'b0, v0 & ~(2'b01 << exp_id)});
         req_valid_i = '0;
      end else begin
         chk("grant", last_grant, exp_id);
      end
   endtask

   task automatic consume(input int id, input int hold);
      int k;
      k = 0;
      while (!rsp_valid_o[id] && k < 100) begin
         step();
         k++;
      end
      if (!rsp_valid_o[id]) begin
         chk("rsp_timeout", {30'b0, rsp_valid_o}, (id == 1) ? 32'd2 : 32'd1);
      end else begin
         repeat (hold) step();
         rsp_ready_i[id] = 1'b1;
         step();
         rsp_ready_i = '0;
      end
   endtask

   task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input int hold);
      set_req(id, a, b, op);
      wait_acc(id);
      consume(id, hold);
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return $urandom_range(0, 40);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int id;
      logic [31:0] a, b;
      logic [1:0] op;

      // ---- reset state, with both requesters already asking ----
      r0_dividend_i = 32'd100; r0_divisor_i = 32'hFFFF_FFF9; r0_op_i = 2'b00;
      r1_dividend_i = 32'd7;   r1_divisor_i = 32'd0;         r1_op_i = 2'b01;
      req_valid_i = 2'b11;
      repeat (3) step();
      chk("reset_ready", {30'b0, req_ready_o}, 32'd0);
      chk("reset_rsp_valid", {30'b0, rsp_valid_o}, 32'd0);
      chk("reset_busy", {31'b0, busy_o}, 32'd0);
      chk("reset_data", rsp_data_o, 32'd0);
      reset_i = 1'b0;

      // first accept on the first edge after reset release, r0 wins the tie
      step();
      chk("first_accept", {30'b0, req_valid_i}, 32'd2);
      chk("first_grant", last_grant, 32'd0);
      chk("busy_run", {31'b0, busy_o}, 32'd1);
      consume(0, 0);                       // 100 / -7 -> -14
      wait_acc(1);                         // r1 next: 7 /u 0 -> all ones
      consume(1, 0);

      // both valid again: r0 (r1 served last); hold the response 10 cycles
      set_req(0, 32'd100, 32'hFFFF_FFF9, 2'b10);
      set_req(1, 32'd7, 32'd0, 2'b11);
      wait_acc(0);
      consume(0, 10);
      wait_acc(1);
      consume(1, 0);

      // r1 alone, signed divide by zero
      run_op(1, 32'hFFFF_FFF9, 32'd0, 2'b00, 0);
      // signed overflow quotient and remainder
      run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 0);
      run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 1);

      // ---- owner cancel mid-RUN leaves the pointer alone ----
      run_op(1, 32'd7, 32'd3, 2'b01, 0);   // r1 served last
      set_req(0, 32'd1000, 32'd9, 2'b00);
      wait_acc(0);
      repeat (9) step();
      cancel_i = 2'b01;
      void'(sb.pop_back());
      step();
      cancel_i = 2'b00;
      chk("cancel_busy", {31'b0, busy_o}, 32'd0);
      chk("cancel_rsp_valid", {30'b0, rsp_valid_o}, 32'd0);
      set_req(0, 32'd55, 32'd5, 2'b01);
      set_req(1, 32'd56, 32'd5, 2'b11);
      wait_acc(0);                         // pointer still favours r0
      consume(0, 0);
      wait_acc(1);
      consume(1, 0);

      // ---- non-owner cancel is ignored ----
      set_req(0, 32'hFFFF_FF00, 32'd16, 2'b00);
      wait_acc(0);
      repeat (5) step();
      cancel_i = 2'b10;
      step();
      cancel_i = 2'b00;
      consume(0, 2);

      // ---- cancel + ready on the same RESP edge counts as a consume ----
      run_op(1, 32'd9, 32'd2, 2'b01, 0);   // r1 served last
      set_req(0, 32'd123, 32'hFFFF_FFFE, 2'b10);
      wait_acc(0);
      consume(0, 0);
      rsp_ready_i = '0;
      // redo last consume edge with cancel also asserted on a fresh op
      run_op(1, 32'd9, 32'd2, 2'b01, 0);   // r1 served last again
      set_req(0, 32'd321, 32'd10, 2'b01);
      wait_acc(0);
      begin
         int k;
         k = 0;
         while (!rsp_valid_o[0] && k < 100) begin step(); k++; end
      end
      rsp_ready_i = 2'b01;
      cancel_i = 2'b01;
      step();
      rsp_ready_i = 2'b00;
      cancel_i = 2'b00;
      chk("cancel_ready_busy", {31'b0, busy_o}, 32'd0);
      set_req(0, 32'd17, 32'd4, 2'b00);
      set_req(1, 32'd18, 32'd4, 2'b00);
      wait_acc(1);                         // pointer flipped to r0
      consume(1, 0);
      wait_acc(0);
      consume(0, 0);                       // r0 served last

      // ---- reset mid-RUN ----
      set_req(1, 32'd77, 32'd7, 2'b01);
      wait_acc(1);
      repeat (20) step();
      void'(sb.pop_back());
      reset_i = 1'b1;
      set_req(0, 32'd40, 32'd6, 2'b01);
      set_req(1, 32'd41, 32'd6, 2'b01);
      step();
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_rsp_valid", {30'b0, rsp_valid_o}, 32'd0);
      chk("rst_ready", {30'b0, req_ready_o}, 32'd0);
      chk("rst_data", rsp_data_o, 32'd0);
      reset_i = 1'b0;
      step();
      chk("rst_first_accept", {30'b0, req_valid_i}, 32'd2);
      chk("rst_grant", last_grant, 32'd0);
      consume(0, 0);
      wait_acc(1);
      consume(1, 0);

      // ---- randomized traffic ----
      for (int n = 0; n < 24; n++) begin
         id = $urandom_range(0, 1);
         a  = rand_opnd();
         b  = rand_opnd();
         op = 2'($urandom_range(0, 3));
         run_op(id, a, b, op, $urandom_range(0, 3));
      end

      repeat (5) step();
      chk("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-002 reset_i  in  1  synchronous, active-high reset.
REQ-003 req_valid_i  in  2  per-requester request valid; bit0 = integer execute, bit1 = FPU.
REQ-004 req_ready_o  out  2  per-requester accept; request accepted on the edge where valid and ready are both 1.
REQ-005 r0_dividend_i, r0_divisor_i  in  32 each  requester-0 operands.
REQ-006 r0_op_i  in  2  requester-0 op: bit0 = unsigned, bit1 = remainder (matches funct3[1:0] of DIV/DIVU/REM/REMU).
REQ-007 r1_dividend_i, r1_divisor_i, r1_op_i  in  32/32/2  requester-1 equivalents.
REQ-008 cancel_i  in  2  per-requester abort of an in-flight op.
REQ-009 rsp_valid_o  out  2  one-hot result valid, owner bit only.
REQ-010 rsp_ready_i  in  2  per-requester result consume.
REQ-011 rsp_data_o  out  32  result, shared by both requesters.
REQ-012 busy_o  out  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FIX, RESP; the block SHALL hold one owner register (1 bit) and one round-robin pointer (1 bit).
REQ-014 req_ready_o SHALL be nonzero only in IDLE and only for the granted requester (one-hot or zero).
REQ-015 Grant: a single valid requester is granted; if both are valid, the requester not served last is granted; the pointer after reset favours requester 0.
REQ-016 On accept: latch owner and op; latch |dividend| and |divisor| (magnitude only when op bit0 = 0 and the operand is negative); go to RUN with the step counter set to 31.
REQ-017 Sign flag: for quotient, negative = signed AND sign(dividend) != sign(divisor) AND divisor != 0; for remainder, negative = signed AND sign(dividend).
REQ-018 RUN SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles (quotient MSB first), then go to FIX.
REQ-019 FIX (1 cycle) SHALL select the quotient or remainder per op bit1, negate it if the sign flag is set, register the value to rsp_data_o, and go to RESP.
REQ-020 rsp_valid_o[owner] SHALL rise 34 edges after the accepting edge and hold, with rsp_data_o stable, until rsp_ready_i[owner] = 1; on that edge go to IDLE and flip the pointer to the owner.
REQ-021 No bypass: the IDLE entered on response consumption accepts no earlier than the next edge, so back-to-back throughput is 1 op per 35 cycles minimum.
REQ-022 Divide by zero SHALL yield quotient 0xFFFFFFFF and remainder = dividend, both signed and unsigned.
REQ-023 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0.
REQ-024 cancel_i[owner] in RUN, FIX or RESP SHALL discard the op: next state IDLE, rsp_valid_o = 0, pointer unchanged. cancel_i of a non-owner, or any cancel_i in IDLE, SHALL be ignored.
REQ-025 Cancel and rsp_ready_i asserted by the owner on the same RESP edge SHALL be treated as a consume: pointer flips, no further response.
REQ-026 req_valid_i deasserting while not ready SHALL have no effect; operands are sampled only on the accept edge.

Reset
REQ-027 reset_i SHALL force IDLE, rsp_valid_o = 0, req_ready_o = 0 during the reset cycle, rsp_data_o = 0, pointer favouring requester 0, and owner = 0.
REQ-028 Reset asserted mid-RUN/FIX/RESP SHALL abandon the operation with no response ever produced for it.
REQ-029 The first accept SHALL be possible on the first edge after reset_i deasserts.

Verification
REQ-030 Signed quotients: r0 op=00, 100 / 0xFFFFFFF9 (-7) -> rsp_valid_o = 01 at accept+34, data 0xFFFFFFF2. With op=10 -> data 0x00000002.
REQ-031 Unsigned divide by zero: r1 op=01, 7 / 0 -> 0xFFFFFFFF. With op=11 -> 0x00000007. Signed op=00, 0xFFFFFFF9 / 0 -> 0xFFFFFFFF.
REQ-032 Signed overflow: op=00, 0x80000000 / 0xFFFFFFFF -> 0x80000000. With op=10 -> 0x00000000.
REQ-033 Arbitration: both valid right after reset -> r0 granted, r1 granted after r0's response. Both valid again -> r0 granted. With r1 valid alone after that -> r1 granted. req_ready_o is never 11.
REQ-034 Hold and cancel: hold rsp_ready_i = 0 for 10 cycles -> rsp_valid_o and data stay stable. Assert cancel_i[0] at RUN step 10 -> no response, busy_o low the next cycle, pointer unchanged.
REQ-035 Reset at RUN step 20 -> IDLE next cycle, all outputs at reset values, and a new request completes normally.
